// File: rtl/etaoin_encoder_stream.sv
// Streaming ETAOIN substitution encoder with a 2-entry output FIFO and error/letter counters.
// Optional rolling key (effective key advances per encoded letter) enabled by ENC_ROLLING_KEY_EN.
module etaoin_encoder_stream #(
    parameter int KEY   = 3,
    parameter int CNT_W = 16
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             CLR,
    input  logic             PLAIN_VALID,
    output logic             PLAIN_READY,
    input  logic [7:0]       PLAIN,
    output logic             CIPHER_VALID,
    input  logic             CIPHER_READY,
    output logic [7:0]       CIPHER,
    output logic             ERR,
    output logic [CNT_W-1:0] CHAR_CNT,
    output logic [CNT_W-1:0] BAD_CNT
);

    localparam int          KEY_NORM = ((KEY % 12) + 12) % 12;
    localparam logic [3:0]  KEY_MOD  = 4'(KEY_NORM);
    localparam logic [7:0]  CH_SPACE = 8'h20;
    localparam logic [7:0]  CH_LF    = 8'h0A;
    localparam logic [7:0]  CH_BAD   = 8'h3F;

    localparam logic [7:0] ALPHABET [12] = '{
        8'h45, 8'h54, 8'h41, 8'h4F, 8'h49, 8'h4E,
        8'h53, 8'h48, 8'h52, 8'h44, 8'h4C, 8'h55
    };

    // ------------------------------------------------------------------
    // Handshake and FIFO bookkeeping
    // ------------------------------------------------------------------
    logic [1:0] occ_reg, occ_next;
    logic       wr_ptr_reg, wr_ptr_next;
    logic       rd_ptr_reg, rd_ptr_next;
    logic [7:0] mem_reg [2];
    logic       push;
    logic       pop;

    assign PLAIN_READY  = (occ_reg != 2'd2);
    assign CIPHER_VALID = (occ_reg != 2'd0);
    assign CIPHER       = mem_reg[rd_ptr_reg];
    assign push         = PLAIN_VALID && PLAIN_READY;
    assign pop          = CIPHER_VALID && CIPHER_READY;

    // ------------------------------------------------------------------
    // Character classification and mapping
    // ------------------------------------------------------------------
    logic [11:0] hit;
    logic        is_letter;
    logic        is_pass;
    logic [3:0]  plain_idx;
    logic [3:0]  eff_key;
    logic [4:0]  enc_sum;
    logic [3:0]  enc_idx;
    logic [7:0]  enc_char;

    genvar gi;
    generate
        for (gi = 0; gi < 12; gi++) begin : g_match
            assign hit[gi] = (PLAIN == ALPHABET[gi]);
        end
    endgenerate

`ifdef ENC_ROLLING_KEY_EN
    logic [3:0] ofs_reg, ofs_next;
    logic [4:0] key_sum;

    assign key_sum = {1'b0, KEY_MOD} + {1'b0, ofs_reg};
    assign eff_key = (key_sum >= 5'd12) ? 4'(key_sum - 5'd12) : key_sum[3:0];
`else
    assign eff_key = KEY_MOD;
`endif

    always_comb begin
        is_letter = |hit;
        is_pass   = (PLAIN == CH_SPACE) || (PLAIN == CH_LF);
        plain_idx = 4'd0;
        for (int i = 0; i < 12; i++) begin
            if (hit[i]) begin
                plain_idx = 4'(i);
            end
        end
        enc_sum = {1'b0, plain_idx} + {1'b0, eff_key};
        enc_idx = (enc_sum >= 5'd12) ? 4'(enc_sum - 5'd12) : enc_sum[3:0];
        if (is_letter) begin
            enc_char = ALPHABET[enc_idx];
        end else if (is_pass) begin
            enc_char = PLAIN;
        end else begin
            enc_char = CH_BAD;
        end
    end

    // ------------------------------------------------------------------
    // FIFO next state
    // ------------------------------------------------------------------
    always_comb begin
        occ_next    = occ_reg;
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        if (push) begin
            wr_ptr_next = ~wr_ptr_reg;
        end
        if (pop) begin
            rd_ptr_next = ~rd_ptr_reg;
        end
        case ({push, pop})
            2'b10:   occ_next = occ_reg + 2'd1;
            2'b01:   occ_next = occ_reg - 2'd1;
            default: occ_next = occ_reg;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            occ_reg    <= 2'd0;
            wr_ptr_reg <= 1'b0;
            rd_ptr_reg <= 1'b0;
        end else begin
            occ_reg    <= occ_next;
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
        end
    end

    // Entries are cleared on reset so CIPHER reads 0x00 afterwards.
    generate
        for (gi = 0; gi < 2; gi++) begin : g_entry
            always_ff @(posedge CLK) begin
                if (!RST_N) begin
                    mem_reg[gi] <= 8'h00;
                end else if (push && (wr_ptr_reg == 1'(gi))) begin
                    mem_reg[gi] <= enc_char;
                end
            end
        end
    endgenerate

    // ------------------------------------------------------------------
    // Status counters; CLR has priority over a coincident accept
    // ------------------------------------------------------------------
    logic             err_reg, err_next;
    logic [CNT_W-1:0] char_cnt_reg, char_cnt_next;
    logic [CNT_W-1:0] bad_cnt_reg, bad_cnt_next;

    always_comb begin
        err_next      = err_reg;
        char_cnt_next = char_cnt_reg;
        bad_cnt_next  = bad_cnt_reg;
        if (CLR) begin
            err_next      = 1'b0;
            char_cnt_next = '0;
            bad_cnt_next  = '0;
        end else if (push) begin
            if (is_letter) begin
                if (char_cnt_reg != '1) begin
                    char_cnt_next = char_cnt_reg + CNT_W'(1);
                end
            end else if (!is_pass) begin
                err_next = 1'b1;
                if (bad_cnt_reg != '1) begin
                    bad_cnt_next = bad_cnt_reg + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            err_reg      <= 1'b0;
            char_cnt_reg <= '0;
            bad_cnt_reg  <= '0;
        end else begin
            err_reg      <= err_next;
            char_cnt_reg <= char_cnt_next;
            bad_cnt_reg  <= bad_cnt_next;
        end
    end

`ifdef ENC_ROLLING_KEY_EN
    always_comb begin
        ofs_next = ofs_reg;
        if (CLR) begin
            ofs_next = 4'd0;
        end else if (push && is_letter) begin
            ofs_next = (ofs_reg == 4'd11) ? 4'd0 : ofs_reg + 4'd1;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            ofs_reg <= 4'd0;
        end else begin
            ofs_reg <= ofs_next;
        end
    end
`endif

    assign ERR      = err_reg;
    assign CHAR_CNT = char_cnt_reg;
    assign BAD_CNT  = bad_cnt_reg;

endmodule

// File: tb/tb_etaoin_encoder_stream.sv
// Directed plus randomized bench for etaoin_encoder_stream, checked against a queue-based reference model.
module tb_etaoin_encoder_stream;

    localparam int TB_KEY   = 3;
    localparam int TB_CNT_W = 4;
    localparam int CNT_MAX  = (1 << TB_CNT_W) - 1;

    logic                CLK = 1'b0;
    logic                RST_N;
    logic                CLR;
    logic                PLAIN_VALID;
    logic                PLAIN_READY;
    logic [7:0]          PLAIN;
    logic                CIPHER_VALID;
    logic                CIPHER_READY;
    logic [7:0]          CIPHER;
    logic                ERR;
    logic [TB_CNT_W-1:0] CHAR_CNT;
    logic [TB_CNT_W-1:0] BAD_CNT;

    etaoin_encoder_stream #(.KEY(TB_KEY), .CNT_W(TB_CNT_W)) dut (
        .CLK          (CLK),
        .RST_N        (RST_N),
        .CLR          (CLR),
        .PLAIN_VALID  (PLAIN_VALID),
        .PLAIN_READY  (PLAIN_READY),
        .PLAIN        (PLAIN),
        .CIPHER_VALID (CIPHER_VALID),
        .CIPHER_READY (CIPHER_READY),
        .CIPHER       (CIPHER),
        .ERR          (ERR),
        .CHAR_CNT     (CHAR_CNT),
        .BAD_CNT      (BAD_CNT)
    );

    always #5 CLK = ~CLK;

    // Reference model state
    string         alpha = "ETAOINSHRDLU";
    byte unsigned  exp_q[$];
    byte unsigned  log_q[$];
    int            m_char;
    int            m_bad;
    int            m_ofs;
    bit            m_err;
    int            tests;
    int            fails;

    function automatic int letter_pos(byte unsigned c);
        for (int i = 0; i < 12; i++) begin
            if (byte'(alpha[i]) == c) return i;
        end
        return -1;
    endfunction

    function automatic byte unsigned ref_encode(byte unsigned c, int ofs);
        int p;
        p = letter_pos(c);
        if (p >= 0) return byte'(alpha[(p + TB_KEY + ofs) % 12]);
        if (c == 8'h20 || c == 8'h0A) return c;
        return 8'h3F;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        exp_q.delete();
        m_char = 0;
        m_bad  = 0;
        m_ofs  = 0;
        m_err  = 0;
    endtask

    // One clock: compare outputs against the model, advance the model, then cross the edge.
    task automatic tick();
        bit           do_push;
        bit           do_pop;
        byte unsigned c;
        check("plain_ready", PLAIN_READY, exp_q.size() != 2);
        check("cipher_valid", CIPHER_VALID, exp_q.size() != 0);
        if (exp_q.size() != 0) check("cipher", CIPHER, exp_q[0]);
        check("err", ERR, m_err);
        check("char_cnt", CHAR_CNT, m_char);
        check("bad_cnt", BAD_CNT, m_bad);
        if (!RST_N) begin
            model_clear();
        end else begin
            do_push = PLAIN_VALID && (exp_q.size() != 2);
            do_pop  = (exp_q.size() != 0) && CIPHER_READY;
            if (do_pop) begin
                c = exp_q.pop_front();
                log_q.push_back(c);
                $display("[TB] t=%0t out 0x%02h", $time, c);
            end
            if (do_push) exp_q.push_back(ref_encode(PLAIN, m_ofs));
            if (CLR) begin
                m_char = 0;
                m_bad  = 0;
                m_err  = 0;
                m_ofs  = 0;
            end else if (do_push) begin
                if (letter_pos(PLAIN) >= 0) begin
                    if (m_char < CNT_MAX) m_char++;
`ifdef ENC_ROLLING_KEY_EN
                    m_ofs = (m_ofs + 1) % 12;
`endif
                end else if (PLAIN != 8'h20 && PLAIN != 8'h0A) begin
                    m_err = 1;
                    if (m_bad < CNT_MAX) m_bad++;
                end
            end
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic send_str(input string s);
        CIPHER_READY = 1'b1;
        for (int i = 0; i < s.len(); i++) begin
            PLAIN_VALID = 1'b1;
            PLAIN       = s[i];
            tick();
        end
        PLAIN_VALID = 1'b0;
        repeat (3) tick();
    endtask

    task automatic pulse_clr();
        CLR = 1'b1;
        tick();
        CLR = 1'b0;
    endtask

    task automatic check_log(input string tag, input string exp);
        check({tag, "_len"}, log_q.size(), exp.len());
        for (int i = 0; i < exp.len() && i < log_q.size(); i++) begin
            check(tag, log_q[i], exp[i]);
        end
        log_q.delete();
    endtask

    initial begin
        string s_hat, s_ue, s_bp;
        tests = 0;
        fails = 0;
`ifdef ENC_ROLLING_KEY_EN
        s_hat = "LSS";
        s_ue  = "A I";
        s_bp  = "ON";
`else
        s_hat = "LNI";
        s_ue  = "A O";
        s_bp  = "OI";
`endif
        RST_N = 1'b0; CLR = 1'b0; PLAIN_VALID = 1'b0; PLAIN = 8'h00; CIPHER_READY = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        model_clear();
        check("rst_cipher", CIPHER, 8'h00);
        check("rst_cipher_valid", CIPHER_VALID, 1'b0);
        check("rst_plain_ready", PLAIN_READY, 1'b1);
        RST_N = 1'b1;
        tick();

        // HAT: first output visible one cycle after the first accept
        CIPHER_READY = 1'b1;
        PLAIN_VALID  = 1'b1;
        PLAIN        = "H";
        tick();
        check("hat_first_valid", CIPHER_VALID, 1'b1);
        check("hat_first_char", CIPHER, "L");
        send_str("AT");
        check_log("hat", s_hat);
        check("hat_cnt", CHAR_CNT, 3);
        check("hat_err", ERR, 1'b0);

        // Wrap-around and space pass-through
        pulse_clr();
        send_str("U E");
        check_log("ue", s_ue);
        check("ue_cnt", CHAR_CNT, 2);

        // Backpressure: 3 offered, only 2 taken
        pulse_clr();
        CIPHER_READY = 1'b0;
        PLAIN_VALID  = 1'b1;
        PLAIN = "E"; tick();
        PLAIN = "T"; tick();
        PLAIN = "A"; tick();
        check("bp_ready_full", PLAIN_READY, 1'b0);
        PLAIN_VALID = 1'b0;
        repeat (2) tick();
        CIPHER_READY = 1'b1;
        tick();
        check("bp_ready_back", PLAIN_READY, 1'b1);
        repeat (3) tick();
        check_log("bp", s_bp);
        check("bp_cnt", CHAR_CNT, 2);

        // Illegal byte, then CLR
        pulse_clr();
        send_str("Hx");
        check_log("hx", "L?");
        check("hx_err", ERR, 1'b1);
        check("hx_bad", BAD_CNT, 1);
        check("hx_cnt", CHAR_CNT, 1);
        pulse_clr();
        check("clr_err", ERR, 1'b0);
        check("clr_bad", BAD_CNT, 0);
        check("clr_cnt", CHAR_CNT, 0);

        // Reset with FIFO full
        CIPHER_READY = 1'b0;
        PLAIN_VALID  = 1'b1;
        PLAIN = "S"; tick();
        PLAIN = "R"; tick();
        check("full_before_rst", PLAIN_READY, 1'b0);
        RST_N = 1'b0;
        tick();
        RST_N = 1'b1;
        PLAIN_VALID = 1'b0;
        check("mrst_valid", CIPHER_VALID, 1'b0);
        check("mrst_ready", PLAIN_READY, 1'b1);
        check("mrst_cipher", CIPHER, 8'h00);
        check("mrst_cnt", CHAR_CNT, 0);
        check("mrst_bad", BAD_CNT, 0);
        check("mrst_err", ERR, 1'b0);
        log_q.delete();
        tick();

        // 15 E's: rolling build wraps back to O on the 13th; counter saturates at 15
        pulse_clr();
        send_str("EEEEEEEEEEEEEEE");
        check("e13", log_q.size() >= 13 ? log_q[12] : 8'h00, "O");
`ifdef ENC_ROLLING_KEY_EN
        check_log("eee", "OINSHRDLUETAOIN");
`else
        check_log("eee", "OOOOOOOOOOOOOOO");
`endif
        check("sat_cnt", CHAR_CNT, CNT_MAX);
        send_str("E");
        check("sat_hold", CHAR_CNT, CNT_MAX);
        log_q.delete();

        // Randomized traffic
        for (int n = 0; n < 1500; n++) begin
            int r;
            r = $urandom_range(0, 9);
            if (r <= 5)      PLAIN = alpha[$urandom_range(0, 11)];
            else if (r == 6) PLAIN = 8'h20;
            else if (r == 7) PLAIN = 8'h0A;
            else if (r == 8) PLAIN = 8'(8'h61 + $urandom_range(0, 25));
            else             PLAIN = 8'($urandom_range(0, 255));
            PLAIN_VALID  = ($urandom_range(0, 9) < 7);
            CIPHER_READY = ($urandom_range(0, 9) < 6);
            CLR          = ($urandom_range(0, 39) == 0);
            RST_N        = ($urandom_range(0, 99) != 0);
            tick();
        end
        RST_N = 1'b1; CLR = 1'b0; PLAIN_VALID = 1'b0;
        log_q.delete();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
